// File: rtl/mult_seq.sv
// mult_seq: multi-cycle multiply / shift sequencer beside the control unit.
// Radix-2 shift-add multiply (MULU/MULS) and one-bit-per-cycle shifts (SHL/SAR).
module mult_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [4:0] MAX_SH = 5'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_FIX,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          state, state_n;
   logic [1:0]      op_q, op_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [W2-1:0]   mcand, mcand_n;
   logic [WIDTH-1:0] mplier, mplier_n;
   logic [W2-1:0]   acc, acc_n;
   logic            neg, neg_n;
   logic [WIDTH-1:0] lo_n, hi_n;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [CW-1:0]   amt;
   logic [W2-1:0]   fix_val, sh_val;

   assign a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
   assign b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;
   assign amt = (operand_b[4:0] > MAX_SH) ? CW'(WIDTH) : CW'(operand_b[4:0]);
   assign fix_val = neg ? -acc : acc;
   // op_q[0] distinguishes SAR (sign-fill within the low half) from SHL
   assign sh_val = op_q[0] ? {{WIDTH{1'b0}}, acc[WIDTH-1], acc[WIDTH-1:1]}
                           : {acc[W2-2:0], 1'b0};

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= '0;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         neg       <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
      end else begin
         state     <= state_n;
         op_q      <= op_n;
         cnt       <= cnt_n;
         mcand     <= mcand_n;
         mplier    <= mplier_n;
         acc       <= acc_n;
         neg       <= neg_n;
         result_lo <= lo_n;
         result_hi <= hi_n;
      end
   end

   always_comb begin
      state_n  = state;
      op_n     = op_q;
      cnt_n    = cnt;
      mcand_n  = mcand;
      mplier_n = mplier;
      acc_n    = acc;
      neg_n    = neg;
      lo_n     = result_lo;
      hi_n     = result_hi;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               op_n     = op;
               cnt_n    = '0;
               acc_n    = '0;
               neg_n    = 1'b0;
               mcand_n  = {{WIDTH{1'b0}}, operand_a};
               mplier_n = operand_b;
               if (!op[1]) begin
                  if (op[0]) begin
                     mcand_n  = {{WIDTH{1'b0}}, a_mag};
                     mplier_n = b_mag;
                     neg_n    = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                  end
                  state_n = S_MUL;
               end else begin
                  acc_n = {{WIDTH{1'b0}}, operand_a};
                  cnt_n = amt;
                  if (amt == '0) begin
                     lo_n    = operand_a;
                     hi_n    = '0;
                     state_n = S_DONE;
                  end else begin
                     state_n = S_SHIFT;
                  end
               end
            end
         end
         S_MUL: begin
            if (mplier[0]) acc_n = acc + mcand;
            mplier_n = mplier >> 1;
            mcand_n  = mcand << 1;
            cnt_n    = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state_n = S_FIX;
         end
         S_FIX: begin
            acc_n        = fix_val;
            {hi_n, lo_n} = fix_val;
            state_n      = S_DONE;
         end
         S_SHIFT: begin
            acc_n = sh_val;
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               {hi_n, lo_n} = sh_val;
               state_n      = S_DONE;
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

endmodule
